// File: rtl/abc_window_accum.sv
// Windowed accumulator behind the A*B+C stage: sums WINDOW valid results and
// hands each completed sum to a one-entry valid/ready output with overrun flag.
module abc_window_accum #(
  parameter int LENGTH = 8,
  parameter int WINDOW = 4,
  localparam int ACC_W = 2*LENGTH + ((WINDOW > 1) ? $clog2(WINDOW) : 0),
  localparam int CNT_W = $clog2(WINDOW+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [2*LENGTH-1:0] in_data,
  input  logic                clear,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic [CNT_W-1:0]    fill_cnt,
  output logic                overrun
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] eff_cnt;
  logic [ACC_W-1:0] sum;
  logic             complete;

  function automatic logic [ACC_W-1:0] widen(input logic [2*LENGTH-1:0] d);
    widen = ACC_W'(d);
  endfunction

  // A clear restarts the window on this very edge, so the sampled input is
  // judged against an empty window rather than the discarded partial one.
  always_comb begin
    eff_cnt  = clear ? '0 : fill_cnt;
    sum      = (eff_cnt == '0) ? widen(in_data) : acc + widen(in_data);
    complete = in_valid && (eff_cnt == CNT_W'(WINDOW-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      fill_cnt <= '0;
    end else if (in_valid) begin
      acc      <= sum;
      fill_cnt <= complete ? '0 : eff_cnt + CNT_W'(1);
    end else begin
      fill_cnt <= eff_cnt;
    end
  end

  // Output FSM; out_valid mirrors HOLD as a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (clear) overrun <= 1'b0;
      case (state)
        EMPTY: begin
          if (complete) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= sum;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (complete) begin
              out_data <= sum;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end else if (complete) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abc_window_accum.sv
// Directed bench for abc_window_accum (LENGTH=8, WINDOW=4).
module tb_abc_window_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic [2:0]  fill_cnt;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  abc_window_accum #(.LENGTH(8), .WINDOW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fill_cnt(fill_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", out_valid); end
    checks++; if (out_data !== 18'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    checks++; if (fill_cnt !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0d exp=0", overrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    put(1'b1, 16'd10);
    checks++; if (fill_cnt !== 3'd1) begin failures++; $display("FAIL basic_fill1 got=%0d exp=1", fill_cnt); end
    put(1'b1, 16'd20);
    checks++; if (fill_cnt !== 3'd2) begin failures++; $display("FAIL basic_fill2 got=%0d exp=2", fill_cnt); end
    put(1'b1, 16'd30);
    checks++; if (fill_cnt !== 3'd3) begin failures++; $display("FAIL basic_fill3 got=%0d exp=3", fill_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0d exp=0", out_valid); end
    put(1'b1, 16'd40);
    checks++; if (fill_cnt !== 3'd0) begin failures++; $display("FAIL basic_fill_wrap got=%0d exp=0", fill_cnt); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0d exp=1", out_valid); end
    checks++; if (out_data !== 18'd100) begin failures++; $display("FAIL basic_data got=%0d exp=100", out_data); end
    put(1'b0, 16'd0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0d exp=0", out_valid); end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    put(1'b1, 16'd1);
    put(1'b0, 16'd99);
    checks++; if (fill_cnt !== 3'd1) begin failures++; $display("FAIL gap_fill_hold got=%0d exp=1", fill_cnt); end
    put(1'b1, 16'd2);
    put(1'b0, 16'd77);
    put(1'b0, 16'd55);
    put(1'b1, 16'd3);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_early_valid got=%0d exp=0", out_valid); end
    put(1'b1, 16'd4);
    checks++; if (out_data !== 18'd10 || out_valid !== 1'b1) begin failures++; $display("FAIL gap_sum got=%0d/%0d exp=10/1", out_data, out_valid); end
    put(1'b0, 16'd0);
  endtask

  task automatic test_max();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(1'b1, 16'hFFFF);
    checks++; if (out_data !== 18'd262140) begin failures++; $display("FAIL max_sum got=%0d exp=262140", out_data); end
    for (int i = 0; i < 4; i++) put(1'b1, 16'd1);
    checks++; if (out_data !== 18'd4 || out_valid !== 1'b1) begin failures++; $display("FAIL max_restart got=%0d/%0d exp=4/1", out_data, out_valid); end
    put(1'b0, 16'd0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    put(1'b1, 16'd10); put(1'b1, 16'd20); put(1'b1, 16'd30); put(1'b1, 16'd40);
    put(1'b0, 16'd0);
    checks++; if (out_valid !== 1'b1 || out_data !== 18'd100) begin failures++; $display("FAIL bp_hold got=%0d/%0d exp=1/100", out_valid, out_data); end
    for (int i = 0; i < 4; i++) put(1'b1, 16'd5);
    checks++; if (out_data !== 18'd100) begin failures++; $display("FAIL bp_keep_old got=%0d exp=100", out_data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun got=%0d exp=1", overrun); end
    out_ready = 1'b1;
    put(1'b0, 16'd0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%0d exp=0", out_valid); end
    put(1'b0, 16'd0);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%0d exp=1", overrun); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp_clear_overrun got=%0d exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    put(1'b1, 16'd10); put(1'b1, 16'd20); put(1'b1, 16'd30); put(1'b1, 16'd40);
    put(1'b1, 16'd5); put(1'b1, 16'd5); put(1'b1, 16'd5);
    checks++; if (out_data !== 18'd100 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold got=%0d/%0d exp=100/1", out_data, out_valid); end
    out_ready = 1'b1;
    put(1'b1, 16'd5);
    checks++; if (out_valid !== 1'b1 || out_data !== 18'd20) begin failures++; $display("FAIL b2b_load got=%0d/%0d exp=1/20", out_valid, out_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0d exp=0", overrun); end
    put(1'b0, 16'd0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", out_valid); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(1'b1, 16'd1);
    put(1'b1, 16'd7); put(1'b1, 16'd7);
    clear = 1'b1;
    put(1'b1, 16'd3);
    clear = 1'b0;
    checks++; if (fill_cnt !== 3'd1) begin failures++; $display("FAIL clr_fill got=%0d exp=1", fill_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 18'd4) begin failures++; $display("FAIL clr_held got=%0d/%0d exp=1/4", out_valid, out_data); end
    out_ready = 1'b1;
    put(1'b1, 16'd3);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_consume got=%0d exp=0", out_valid); end
    put(1'b1, 16'd3);
    put(1'b1, 16'd3);
    checks++; if (out_valid !== 1'b1 || out_data !== 18'd12) begin failures++; $display("FAIL clr_sum got=%0d/%0d exp=1/12", out_valid, out_data); end
    put(1'b0, 16'd0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    put(1'b1, 16'd10); put(1'b1, 16'd20); put(1'b1, 16'd30); put(1'b1, 16'd40);
    put(1'b1, 16'd1); put(1'b1, 16'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 18'd0) begin failures++; $display("FAIL arst_out got=%0d/%0d exp=0/0", out_valid, out_data); end
    checks++; if (fill_cnt !== 3'd0 || overrun !== 1'b0) begin failures++; $display("FAIL arst_ctl got=%0d/%0d exp=0/0", fill_cnt, overrun); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    put(1'b1, 16'd1); put(1'b1, 16'd2); put(1'b1, 16'd3); put(1'b1, 16'd4);
    checks++; if (out_valid !== 1'b1 || out_data !== 18'd10) begin failures++; $display("FAIL arst_after got=%0d/%0d exp=1/10", out_valid, out_data); end
    put(1'b0, 16'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
